huffman_encoder_packer: RTL and testbench

Transmit-side counterpart of the multi-symbol JPEG decoder. It accepts one 8-bit symbol per cycle on a valid/ready handshake and maps it through a runtime-programmable 256-entry code table to a 1–14-bit codeword. The codewords are packed MSB-first into a 32-bit bit accumulator and emitted as a byte stream, so its output is the bitstream format the decoder consumes. It sits between the entropy-symbol source and the byte-level output / bitstream buffer.

---
 rtl/huff_enc_pkg.sv | 28 ++
 rtl/huff_enc_code_table.sv | 24 ++
 rtl/huffman_encoder_packer.sv | 126 ++++++++++++
 tb/tb_huffman_encoder_packer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/huff_enc_pkg.sv
// Shared constants, FSM state type and code-table entry type for the Huffman encoder/packer.
// No logic of its own; widths here fix every port and datapath width in the block.
// ones_mask builds a right-justified run of n ones for masking codes and pad bits.
package huff_enc_pkg;
  localparam int CODE_W     = 14;
  localparam int LEN_W      = 4;
  localparam int ACC_W      = 32;
  localparam int CNT_W      = 6;
  localparam int ACCEPT_MAX = 18;

  localparam logic [7:0] STUFF_BYTE = 8'h00;
  localparam logic       PAD_BIT    = 1'b1;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAD   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [LEN_W-1:0]  len;
    logic [CODE_W-1:0] code;
  } tbl_entry_t;

  function automatic logic [ACC_W-1:0] ones_mask(input logic [LEN_W-1:0] n);
    ones_mask = ~({ACC_W{1'b1}} << n);
  endfunction
endpackage

// File: rtl/huff_enc_code_table.sv
// 256-entry {len, code} register file: synchronous write, asynchronous read.
// Read in the same cycle as a write to that address returns the old entry.
// Not reset; contents survive a block reset.
module huff_enc_code_table
  import huff_enc_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [7:0] waddr,
  input  tbl_entry_t wdata,
  input  logic [7:0] raddr,
  output tbl_entry_t rdata
);

  tbl_entry_t mem [0:255];

  // Table write lands on the clock edge
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/huffman_encoder_packer.sv
// Huffman encoder/packer: symbol -> table codeword -> MSB-first 32-bit accumulator -> byte stream.
// Latency: symbol accepted in cycle k, its first full byte shows out_valid in cycle k+2.
// Backpressure: in_ready only while RUN and <=18 bits buffered; out_byte held while !out_ready.
// Optional: HUFF_ENC_BYTE_STUFF_EN inserts a 00 byte after every transferred FF byte.
module huffman_encoder_packer
  import huff_enc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              tbl_we,
  input  logic [7:0]        tbl_addr,
  input  logic [LEN_W-1:0]  tbl_len,
  input  logic [CODE_W-1:0] tbl_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_sym,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_byte,
  output logic              flush_done,
  output logic              err_len0
);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_base, acc_nxt, app_val;
  logic [CNT_W-1:0] count, cnt_base, cnt_nxt, shamt;
  logic [LEN_W-1:0] app_len;
  tbl_entry_t       wr_ent, lut;
  logic             run_rdy, pad_en, drain_done;
  logic             accept, load, take, stuff_pend;

  assign wr_ent.len  = tbl_len;
  assign wr_ent.code = tbl_code;

  huff_enc_code_table u_table (
    .clk   (clk),
    .we    (tbl_we),
    .waddr (tbl_addr),
    .wdata (wr_ent),
    .raddr (in_sym),
    .rdata (lut)
  );

`ifdef HUFF_ENC_BYTE_STUFF_EN
  // A transferred FF forces the byte loaded on that same edge to be the stuff byte
  assign stuff_pend = out_valid && out_ready && (out_byte == 8'hFF);
`else
  assign stuff_pend = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  // Next-state: flush pads once, then drains until everything has left
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (flush) state_nxt = PAD;
      PAD:     state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  // FSM outputs decoded from registered state (reset gates in_ready low)
  always_comb begin
    run_rdy    = (state == RUN) && (count <= CNT_W'(ACCEPT_MAX));
    pad_en     = (state == PAD);
    drain_done = (state == DRAIN) && (count == '0) && !stuff_pend && !out_valid;
    in_ready   = reset && run_rdy;
  end

  // Datapath: drain a byte off the top, then append this cycle's codeword or pad bits
  always_comb begin
    accept   = in_valid && in_ready;
    load     = !out_valid || out_ready;
    take     = load && !stuff_pend && (count >= CNT_W'(8));
    acc_base = take ? (acc << 8) : acc;
    cnt_base = take ? (count - CNT_W'(8)) : count;
    app_len  = '0;
    app_val  = '0;
    if (accept) begin
      app_len = lut.len;
      app_val = ACC_W'(lut.code) & ones_mask(lut.len);
    end else if (pad_en && (count[2:0] != 3'd0)) begin
      app_len = {1'b0, 3'(3'd0 - count[2:0])};
      app_val = {ACC_W{PAD_BIT}} & ones_mask({1'b0, 3'(3'd0 - count[2:0])});
    end
    shamt   = CNT_W'(ACC_W) - cnt_base - CNT_W'(app_len);
    acc_nxt = acc_base | (app_val << shamt);
    cnt_nxt = cnt_base + CNT_W'(app_len);
  end

  // Accumulator, output register and status pulses
  always_ff @(posedge clk) begin
    if (!reset) begin
      acc        <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_byte   <= '0;
      flush_done <= 1'b0;
      err_len0   <= 1'b0;
    end else begin
      acc   <= acc_nxt;
      count <= cnt_nxt;
      if (load) begin
        if (stuff_pend) begin
          out_valid <= 1'b1;
          out_byte  <= STUFF_BYTE;
        end else if (take) begin
          out_valid <= 1'b1;
          out_byte  <= acc[ACC_W-1 -: 8];
        end else begin
          out_valid <= 1'b0;
        end
      end
      flush_done <= drain_done;
      err_len0   <= accept && (lut.len == '0);
    end
  end

endmodule

// File: tb/tb_huffman_encoder_packer.sv
// Self-checking bench for huffman_encoder_packer: table-driven single-symbol vectors,
// hand-written sequences for stuffing, backpressure, len-0, write/lookup race and reset,
// and a byte scoreboard fed by stimulus and drained by an output monitor.
module tb_huffman_encoder_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        tbl_we = 1'b0;
  logic [7:0]  tbl_addr = '0;
  logic [3:0]  tbl_len = '0;
  logic [13:0] tbl_code = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_sym = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  out_byte;
  logic        flush_done;
  logic        err_len0;

  huffman_encoder_packer dut (
    .clk(clk), .reset(reset),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_len(tbl_len), .tbl_code(tbl_code),
    .in_valid(in_valid), .in_ready(in_ready), .in_sym(in_sym),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
    .flush_done(flush_done), .err_len0(err_len0)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int done_cnt = 0;
  int done_base = 0;
  int err_cnt = 0;
  int err_exp = 0;
  bit bp_mode = 1'b0;

  logic [7:0]  exp_q [$];
  bit          bitq [$];
  logic [3:0]  mlen [256];
  logic [13:0] mcode [256];

  typedef struct {
    logic [3:0]  len;
    logic [13:0] code;
    int          nb;
    logic [7:0]  b0;
    logic [7:0]  b1;
  } vec_t;
  vec_t vecs [8];

  task automatic check(input bit ok, input string nm, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (bp_mode) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic prog(input logic [7:0] a, input logic [3:0] l, input logic [13:0] c);
    tbl_we = 1'b1; tbl_addr = a; tbl_len = l; tbl_code = c;
    tick();
    tbl_we = 1'b0;
    mlen[a] = l; mcode[a] = c;
  endtask

  // Reference model: plain bit concatenation, bytes formed every 8 bits
  task automatic push_bit(input bit b);
    logic [7:0] v;
    bitq.push_back(b);
    if (bitq.size() == 8) begin
      for (int i = 0; i < 8; i++) v[7-i] = bitq[i];
      bitq.delete();
      exp_q.push_back(v);
`ifdef HUFF_ENC_BYTE_STUFF_EN
      if (v == 8'hFF) exp_q.push_back(8'h00);
`endif
    end
  endtask

  task automatic model_append(input logic [7:0] s);
    if (mlen[s] == 4'd0) err_exp++;
    for (int i = int'(mlen[s]) - 1; i >= 0; i--) push_bit(mcode[s][i]);
  endtask

  task automatic model_pad();
    while (bitq.size() != 0) push_bit(1'b1);
  endtask

  task automatic send(input logic [7:0] s, input bit with_flush, input bit track);
    int n = 0;
    in_valid = 1'b1; in_sym = s;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (n >= 200) check(1'b0, "send in_ready timeout", 0, 1);
    else if (track) model_append(s);
    if (with_flush) done_base = done_cnt;
    flush = with_flush;
    tick();
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic pulse_flush();
    done_base = done_cnt;
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    model_pad();
    while (done_cnt == done_base && n < 300) begin tick(); n++; end
    tick(); tick();
    check(done_cnt == done_base + 1, {nm, " flush_done pulses"}, done_cnt - done_base, 1);
    check(exp_q.size() == 0, {nm, " bytes outstanding"}, exp_q.size(), 0);
  endtask

  // Output monitor: scoreboard pop, hold-stability and pulse counting
  bit         prev_hold = 1'b0;
  logic [7:0] prev_byte = '0;
  always @(negedge clk) begin
    logic [7:0] e;
    if (!reset) begin
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) check(out_valid && (out_byte == prev_byte), "out_byte held", out_byte, prev_byte);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check(1'b0, "unexpected byte", out_byte, 0);
        else begin
          e = exp_q.pop_front();
          check(out_byte == e, "out_byte", out_byte, e);
        end
      end
      if (flush_done) done_cnt++;
      if (err_len0) err_cnt++;
      prev_hold = out_valid && !out_ready;
      prev_byte = out_byte;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nsent;
    vecs[0] = '{4'd8,  14'h00A5, 1, 8'hA5, 8'h00};
    vecs[1] = '{4'd3,  14'h0002, 1, 8'h5F, 8'h00};
    vecs[2] = '{4'd1,  14'h0000, 1, 8'h7F, 8'h00};
    vecs[3] = '{4'd14, 14'h2ABC, 2, 8'hAA, 8'hF3};
    vecs[4] = '{4'd5,  14'h0000, 1, 8'h07, 8'h00};
    vecs[5] = '{4'd12, 14'h00F0, 2, 8'h0F, 8'h0F};
    vecs[6] = '{4'd7,  14'h0055, 1, 8'hAB, 8'h00};
    vecs[7] = '{4'd9,  14'h00AA, 2, 8'h55, 8'h7F};

    // Reset state
    tick(); tick(); tick();
    check(out_valid == 1'b0, "reset out_valid", out_valid, 0);
    check(out_byte == 8'h00, "reset out_byte", out_byte, 0);
    check(flush_done == 1'b0, "reset flush_done", flush_done, 0);
    check(err_len0 == 1'b0, "reset err_len0", err_len0, 0);
    check(in_ready == 1'b0, "in_ready during reset", in_ready, 0);
    reset = 1'b1;
    #1;
    check(in_ready == 1'b1, "in_ready after reset", in_ready, 1);

    for (int a = 0; a < 256; a++) prog(8'(a), 4'd0, 14'd0);

    // Latency: accept in cycle k, byte visible in k+2
    prog(8'hA5, 4'd8, 14'h00A5);
    in_valid = 1'b1; in_sym = 8'hA5;
    check(in_ready == 1'b1, "latency in_ready", in_ready, 1);
    exp_q.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    check(out_valid == 1'b0, "latency k+1 out_valid", out_valid, 0);
    tick();
    check(out_valid == 1'b1, "latency k+2 out_valid", out_valid, 1);
    pulse_flush();
    wait_done("latency");

    // Table-driven single-symbol vectors, odd ones flush in the accept cycle
    for (int i = 0; i < 8; i++) begin
      prog(8'h80 + 8'(i), vecs[i].len, vecs[i].code);
      exp_q.push_back(vecs[i].b0);
      if (vecs[i].nb == 2) exp_q.push_back(vecs[i].b1);
      send(8'h80 + 8'(i), i[0], 1'b0);
      if (!i[0]) pulse_flush();
      wait_done($sformatf("vec%0d", i));
    end

    // Byte stuffing
    prog(8'h7E, 4'd8, 14'h00FF);
    prog(8'h12, 4'd8, 14'h0012);
    exp_q.push_back(8'hFF);
`ifdef HUFF_ENC_BYTE_STUFF_EN
    exp_q.push_back(8'h00);
`endif
    exp_q.push_back(8'h12);
    send(8'h7E, 1'b0, 1'b0);
    send(8'h12, 1'b1, 1'b0);
    wait_done("stuff");

    // Backpressure: 14-bit codes with out_ready low; stalls after two symbols
    for (int i = 0; i < 8; i++) prog(8'hB0 + 8'(i), 4'd14, 14'($urandom));
    out_ready = 1'b0;
    in_valid = 1'b1; in_sym = 8'hB0; nsent = 0;
    for (int c = 0; c < 12; c++) begin
      if (in_ready) begin model_append(in_sym); nsent++; end
      tick();
      in_sym = 8'hB0 + 8'(nsent);
    end
    in_valid = 1'b0;
    check(nsent == 2, "bp symbols accepted while stalled", nsent, 2);
    check(in_ready == 1'b0, "bp in_ready stalled", in_ready, 0);
    bp_mode = 1'b1;
    for (int s = 2; s < 8; s++) send(8'hB0 + 8'(s), 1'b0, 1'b1);
    pulse_flush();
    wait_done("bp");
    bp_mode = 1'b0; out_ready = 1'b1;

    // Len-0 symbol consumed without bits: 010 + (none) + 010 + 11 = 4B
    send(8'h81, 1'b0, 1'b1);
    send(8'h33, 1'b0, 1'b1);
    send(8'h81, 1'b0, 1'b1);
    pulse_flush();
    wait_done("len0");
    check(err_cnt == err_exp, "err_len0 pulses", err_cnt, err_exp);
    check(err_cnt == 1, "err_len0 single", err_cnt, 1);

    // Write and lookup of the same address in one cycle uses the old entry
    prog(8'h40, 4'd8, 14'h003C);
    tbl_we = 1'b1; tbl_addr = 8'h40; tbl_len = 4'd8; tbl_code = 14'h00C3;
    in_valid = 1'b1; in_sym = 8'h40;
    check(in_ready == 1'b1, "race in_ready", in_ready, 1);
    exp_q.push_back(8'h3C);
    tick();
    tbl_we = 1'b0; in_valid = 1'b0;
    mlen[8'h40] = 4'd8; mcode[8'h40] = 14'h00C3;
    send(8'h40, 1'b0, 1'b1);
    pulse_flush();
    wait_done("race");

    // Reset mid-stream with 11 bits buffered and a byte pending
    prog(8'h90, 4'd11, 14'h05A5);
    out_ready = 1'b0;
    send(8'hA5, 1'b0, 1'b0);
    send(8'h90, 1'b0, 1'b0);
    tick();
    check(out_valid == 1'b1, "pre-reset out_valid", out_valid, 1);
    reset = 1'b0;
    tick();
    check(out_valid == 1'b0, "mid reset out_valid", out_valid, 0);
    check(in_ready == 1'b0, "mid reset in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    check(in_ready == 1'b1, "post reset in_ready", in_ready, 1);
    out_ready = 1'b1;
    send(8'h81, 1'b0, 1'b1);
    pulse_flush();
    wait_done("post reset");

    check(exp_q.size() == 0, "final scoreboard empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
